// File: rtl/reset_pkg.sv
// reset_pkg: state encoding and reset cause bit positions for reset_sequencer
package reset_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;
  localparam int CAUSE_LOCK = 2;
  localparam int CAUSE_KEY = 1;
  localparam int CAUSE_SW = 0;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: multi-flop level synchronizer with optional stability filter
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic [SYNC_STAGES-1:0] sync;
  logic s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= {SYNC_STAGES{RESET_VAL}};
    else sync <= {sync[SYNC_STAGES-2:0], din};
  assign s = sync[SYNC_STAGES-1];
  if (DEBOUNCE_CYCLES == 1) begin : g_bypass
    assign dout = s;
  end else begin : g_filter
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt;
    // accept a new level only after it has differed for DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        dout <= RESET_VAL;
      end else if (s == dout) cnt <= '0;
      else if (cnt == CNT_MAX) begin
        cnt <= '0;
        dout <= s;
      end else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: system reset from PLL lock, debounced key and software request
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int DEBOUNCE_CYCLES = 38000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_ok,
  input  logic       btn_rst_n,
  input  logic       sw_rst,
  output logic       rst_out,
  output logic [2:0] rst_cause
);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  logic lock_s, key_db, btn_pressed;
  state_t st, nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [2:0] cause_nxt;
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)) u_lock (
    .clk(clk), .rst_n(rst_n), .din(clk_ok), .dout(lock_s)
  );
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_key (
    .clk(clk), .rst_n(rst_n), .din(btn_rst_n), .dout(key_db)
  );
  assign btn_pressed = !key_db;
  always_comb begin
    nxt = st;
    hold_nxt = hold_cnt;
    cause_nxt = rst_cause;
    unique case (st)
      WAIT_LOCK: if (lock_s) begin
        nxt = HOLD;
        hold_nxt = '0;
      end
      HOLD: if (!lock_s) nxt = WAIT_LOCK;
      else if (btn_pressed) hold_nxt = '0;
      else if (hold_cnt == HOLD_MAX) nxt = RUN;
      else hold_nxt = hold_cnt + 1'b1;
      RUN: if (!lock_s) begin
        nxt = WAIT_LOCK;
        cause_nxt = '0;
        cause_nxt[CAUSE_LOCK] = 1'b1;
      end else if (btn_pressed || sw_rst) begin
        nxt = HOLD;
        hold_nxt = '0;
        cause_nxt = '0;
        cause_nxt[btn_pressed ? CAUSE_KEY : CAUSE_SW] = 1'b1;
      end
      default: nxt = WAIT_LOCK;
    endcase
  end
  // rst_out is registered from the next state so it toggles on the RUN entry/exit edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= WAIT_LOCK;
      hold_cnt <= '0;
      rst_cause <= '0;
      rst_out <= 1'b1;
    end else begin
      st <= nxt;
      hold_cnt <= hold_nxt;
      rst_cause <= cause_nxt;
      rst_out <= (nxt != RUN);
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed edge-counted checks of reset_sequencer
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_ok = 1'b1;
  logic btn_rst_n = 1'b1;
  logic sw_rst = 1'b0;
  logic rst_out;
  logic [2:0] rst_cause;
  int errors = 0;
  int checks = 0;
  reset_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_ok(clk_ok), .btn_rst_n(btn_rst_n),
    .sw_rst(sw_rst), .rst_out(rst_out), .rst_cause(rst_cause)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL reset_out got=%b exp=1", rst_out); end
    checks++;
    if (rst_cause !== 3'b000) begin errors++; $display("FAIL reset_cause got=%b exp=000", rst_cause); end
  endtask
  task automatic do_power_on(input string tag);
    rst_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      checks++;
      if (rst_out !== 1'b1) begin errors++; $display("FAIL %s edge%0d rst_out got=%b exp=1", tag, e, rst_out); end
    end
    tick();
    checks++;
    if (rst_out !== 1'b0) begin errors++; $display("FAIL %s edge19 rst_out got=%b exp=0", tag, rst_out); end
    checks++;
    if (rst_cause !== 3'b000) begin errors++; $display("FAIL %s cause got=%b exp=000", tag, rst_cause); end
  endtask
  task automatic test_late_lock;
    rst_n = 1'b0;
    clk_ok = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (9) tick();
    clk_ok = 1'b1;
    repeat (18) tick();
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL late_lock_hold got=%b exp=1", rst_out); end
    tick();
    checks++;
    if (rst_out !== 1'b0) begin errors++; $display("FAIL late_lock_run got=%b exp=0", rst_out); end
    clk_ok = 1'b0;
    repeat (2) tick();
    checks++;
    if (rst_out !== 1'b0) begin errors++; $display("FAIL lock_drop_early got=%b exp=0", rst_out); end
    tick();
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL lock_drop_rst got=%b exp=1", rst_out); end
    checks++;
    if (rst_cause !== 3'b100) begin errors++; $display("FAIL lock_drop_cause got=%b exp=100", rst_cause); end
    repeat (10) tick();
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL wait_lock_stay got=%b exp=1", rst_out); end
    clk_ok = 1'b1;
    repeat (18) tick();
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL relock_hold got=%b exp=1", rst_out); end
    tick();
    checks++;
    if (rst_out !== 1'b0) begin errors++; $display("FAIL relock_run got=%b exp=0", rst_out); end
    checks++;
    if (rst_cause !== 3'b100) begin errors++; $display("FAIL cause_kept got=%b exp=100", rst_cause); end
  endtask
  task automatic test_sw_rst;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL sw_rst_assert got=%b exp=1", rst_out); end
    checks++;
    if (rst_cause !== 3'b001) begin errors++; $display("FAIL sw_rst_cause got=%b exp=001", rst_cause); end
    repeat (4) tick();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL sw_hold_15 got=%b exp=1", rst_out); end
    tick();
    checks++;
    if (rst_out !== 1'b0) begin errors++; $display("FAIL sw_hold_16 got=%b exp=0", rst_out); end
    checks++;
    if (rst_cause !== 3'b001) begin errors++; $display("FAIL sw_cause_run got=%b exp=001", rst_cause); end
  endtask
  task automatic test_key;
    btn_rst_n = 1'b0;
    repeat (5) tick();
    btn_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (rst_out !== 1'b0) begin errors++; $display("FAIL glitch_ignored cyc%0d got=%b exp=0", i, rst_out); end
    end
    btn_rst_n = 1'b0;
    repeat (10) tick();
    checks++;
    if (rst_out !== 1'b0) begin errors++; $display("FAIL key_edge10 got=%b exp=0", rst_out); end
    tick();
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL key_edge11 got=%b exp=1", rst_out); end
    checks++;
    if (rst_cause !== 3'b010) begin errors++; $display("FAIL key_cause got=%b exp=010", rst_cause); end
    repeat (9) tick();
    btn_rst_n = 1'b1;
    repeat (25) tick();
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL key_release_25 got=%b exp=1", rst_out); end
    tick();
    checks++;
    if (rst_out !== 1'b0) begin errors++; $display("FAIL key_release_26 got=%b exp=0", rst_out); end
    checks++;
    if (rst_cause !== 3'b010) begin errors++; $display("FAIL key_cause_run got=%b exp=010", rst_cause); end
  endtask
  task automatic test_simultaneous;
    btn_rst_n = 1'b0;
    repeat (8) tick();
    clk_ok = 1'b0;
    repeat (2) tick();
    checks++;
    if (rst_out !== 1'b0) begin errors++; $display("FAIL simul_pre got=%b exp=0", rst_out); end
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL simul_rst got=%b exp=1", rst_out); end
    checks++;
    if (rst_cause !== 3'b100) begin errors++; $display("FAIL simul_cause got=%b exp=100", rst_cause); end
  endtask
  task automatic test_async_reset;
    btn_rst_n = 1'b1;
    clk_ok = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL async_hold_out got=%b exp=1", rst_out); end
    checks++;
    if (rst_cause !== 3'b000) begin errors++; $display("FAIL async_hold_cause got=%b exp=000", rst_cause); end
    tick();
    do_power_on("repower1");
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    repeat (16) tick();
    checks++;
    if (rst_cause !== 3'b001) begin errors++; $display("FAIL pre_async_cause got=%b exp=001", rst_cause); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rst_out !== 1'b1) begin errors++; $display("FAIL async_run_out got=%b exp=1", rst_out); end
    checks++;
    if (rst_cause !== 3'b000) begin errors++; $display("FAIL async_run_cause got=%b exp=000", rst_cause); end
    tick();
    do_power_on("repower2");
  endtask
  initial begin
    test_reset();
    do_power_on("power_on");
    test_late_lock();
    test_sw_rst();
    test_key();
    test_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
